// File: rtl/aes_cbc_if.sv
// rtl/aes_cbc_if.sv - plaintext in / ciphertext out stream bundle for the CBC controller
interface aes_cbc_if;
    logic         pt_valid;
    logic         pt_ready;
    logic [127:0] pt_data;
    logic         pt_last;
    logic         ct_valid;
    logic         ct_ready;
    logic [127:0] ct_data;
    logic         ct_last;

    modport master (
        output pt_valid, pt_data, pt_last, ct_ready,
        input  pt_ready, ct_valid, ct_data, ct_last
    );

    modport slave (
        input  pt_valid, pt_data, pt_last, ct_ready,
        output pt_ready, ct_valid, ct_data, ct_last
    );
endinterface

// File: rtl/aes_cbc_ctrl.sv
// rtl/aes_cbc_ctrl.sv - CBC chaining controller in front of a combinational AES-128 core
module aes_cbc_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         iv_load,
    input  logic [127:0] iv_in,
    aes_cbc_if.slave     bus,
    output logic [127:0] core_text,
    output logic [127:0] core_key,
    input  logic [127:0] core_cipher,
    output logic         busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_OUT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [127:0]     key_reg;
    logic [127:0]     iv_reg;
    logic [127:0]     chain_reg;
    logic [127:0]     text_reg;
    logic [127:0]     ct_reg;
    logic             last_reg;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             capture;
    logic             retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.pt_ready = 1'b0;
        bus.ct_valid = 1'b0;
        busy         = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;
        retire       = 1'b0;
        case (state)
            ST_IDLE: begin
                // a key/IV load owns the cycle; plaintext waits one cycle
                bus.pt_ready = ~reset & ~key_load & ~iv_load;
                accept       = bus.pt_valid & bus.pt_ready;
                if (accept) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    capture   = 1'b1;
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                busy         = 1'b1;
                bus.ct_valid = 1'b1;
                if (bus.ct_ready) begin
                    retire    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // text_reg/key_reg -> ct_reg/chain_reg through the core is a SETTLE_CYCLES multicycle path
    always_ff @(posedge clk) begin
        if (reset) begin
            key_reg   <= '0;
            iv_reg    <= '0;
            chain_reg <= '0;
            text_reg  <= '0;
            ct_reg    <= '0;
            last_reg  <= 1'b0;
            cnt       <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (key_load) begin
                    key_reg <= key_in;
                end
                if (iv_load) begin
                    iv_reg    <= iv_in;
                    chain_reg <= iv_in;
                end
            end
            if (accept) begin
                text_reg <= bus.pt_data ^ chain_reg;
                last_reg <= bus.pt_last;
                cnt      <= CNT_W'(SETTLE_CYCLES);
            end else if (state == ST_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                ct_reg    <= core_cipher;
                chain_reg <= core_cipher;
            end
            // end of message: the next block chains from the IV again
            if (retire && last_reg) begin
                chain_reg <= iv_reg;
            end
        end
    end

    assign core_text   = text_reg;
    assign core_key    = key_reg;
    assign bus.ct_data = ct_reg;
    assign bus.ct_last = (state == ST_OUT) & last_reg;
endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// tb/tb_aes_cbc_ctrl.sv - bench for aes_cbc_ctrl with a behavioural AES-128 core and CBC model
module tb_aes_cbc_ctrl;
    localparam int SETTLE = 2;

    localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FCT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] SK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SIV = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_load;
    logic [127:0] key_in;
    logic         iv_load;
    logic [127:0] iv_in;
    logic [127:0] core_text;
    logic [127:0] core_key;
    logic [127:0] core_cipher;
    logic [127:0] aes_out;
    logic         busy;
    int           checks = 0;
    int           errors = 0;

    aes_cbc_if bus ();

    aes_cbc_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_load   (key_load),
        .key_in     (key_in),
        .iv_load    (iv_load),
        .iv_in      (iv_in),
        .bus        (bus),
        .core_text  (core_text),
        .core_key   (core_key),
        .core_cipher(core_cipher),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (v^254) then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] r = 8'h01;
        logic [7:0] base = v;
        logic [7:0] e = 8'd254;
        logic [7:0] s;
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            if (e[0]) r = gmul(r, base);
            base = gmul(base, base);
            e = e >> 1;
        end
        s = r;
        t = r;
        for (int k = 0; k < 4; k++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] s;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) b[q+4*c] = a[q+4*((c+q)%4)];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a[4*c]   = gmul(b[4*c], 8'h02) ^ gmul(b[4*c+1], 8'h03) ^ b[4*c+2] ^ b[4*c+3];
                    a[4*c+1] = b[4*c] ^ gmul(b[4*c+1], 8'h02) ^ gmul(b[4*c+2], 8'h03) ^ b[4*c+3];
                    a[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(b[4*c+2], 8'h02) ^ gmul(b[4*c+3], 8'h03);
                    a[4*c+3] = gmul(b[4*c], 8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(b[4*c+3], 8'h02);
                end
            end else begin
                a = b;
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = a[i];
            s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    // Core model: output is only trustworthy once its inputs have been stable SETTLE cycles
    int           age = 0;
    logic [127:0] prev_t = '0;
    logic [127:0] prev_k = '0;
    always_comb aes_out = aes_enc(core_key, core_text);
    always @(negedge clk) begin
        if (core_text !== prev_t || core_key !== prev_k) age = 1;
        else if (age < 100) age = age + 1;
        prev_t = core_text;
        prev_k = core_key;
    end
    assign core_cipher = (age >= SETTLE) ? aes_out : 128'hdeadbeef_0badf00d_deadbeef_0badf00d;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic kl, input logic [127:0] k, input logic il, input logic [127:0] v);
        key_load = kl;
        key_in   = k;
        iv_load  = il;
        iv_in    = v;
        next_cycle();
        key_load = 1'b0;
        iv_load  = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] pt, input logic last,
                              output logic [127:0] ct, output logic ct_l, output int lat);
        int n;
        bus.pt_data  = pt;
        bus.pt_last  = last;
        bus.pt_valid = 1'b1;
        bus.ct_ready = 1'b1;
        n = 0;
        #2;
        while (!bus.pt_ready && n < 50) begin
            next_cycle();
            #2;
            n++;
        end
        chk("accept_timeout", 128'(n < 50), 128'd1);
        next_cycle();
        bus.pt_valid = 1'b0;
        lat = 1;
        #2;
        while (!bus.ct_valid && lat < 50) begin
            next_cycle();
            #2;
            lat++;
        end
        ct   = bus.ct_data;
        ct_l = bus.ct_last;
        next_cycle();
    endtask

    typedef struct {
        logic         do_key;
        logic [127:0] key;
        logic         do_iv;
        logic [127:0] iv;
        logic [127:0] pt;
        logic         last;
        logic [127:0] exp_ct;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] ct;
        logic         ct_l;
        int           lat;

        vecs[0] = '{1'b1, FK, 1'b1, 128'h0, FPT, 1'b1, FCT};
        vecs[1] = '{1'b1, SK, 1'b1, SIV, P1, 1'b0, C1};
        vecs[2] = '{1'b0, 128'h0, 1'b0, 128'h0, P2, 1'b1, C2};
        vecs[3] = '{1'b0, 128'h0, 1'b0, 128'h0, P1, 1'b1, C1};

        reset = 1'b1; key_load = 1'b0; key_in = '0; iv_load = 1'b0; iv_in = '0;
        bus.pt_valid = 1'b1; bus.pt_data = FPT; bus.pt_last = 1'b0; bus.ct_ready = 1'b1;
        next_cycle();
        next_cycle();
        #2;
        chk("rst_pt_ready", 128'(bus.pt_ready), 128'd0);
        chk("rst_ct_valid", 128'(bus.ct_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ct_last", 128'(bus.ct_last), 128'd0);
        chk("rst_ct_data", bus.ct_data, 128'h0);
        chk("rst_core_text", core_text, 128'h0);
        chk("rst_core_key", core_key, 128'h0);
        reset = 1'b0;
        bus.pt_valid = 1'b0;
        next_cycle();

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].do_key || vecs[i].do_iv)
                load(vecs[i].do_key, vecs[i].key, vecs[i].do_iv, vecs[i].iv);
            send_block(vecs[i].pt, vecs[i].last, ct, ct_l, lat);
            chk($sformatf("vec%0d_ct", i), ct, vecs[i].exp_ct);
            chk($sformatf("vec%0d_last", i), 128'(ct_l), 128'(vecs[i].last));
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(SETTLE + 1));
        end

        // backpressure: hold OUT for 10 cycles while a new block is offered
        load(1'b1, FK, 1'b1, 128'h0);
        bus.pt_data = FPT; bus.pt_last = 1'b1; bus.pt_valid = 1'b1; bus.ct_ready = 1'b0;
        #2;
        chk("bp_accept_ready", 128'(bus.pt_ready), 128'd1);
        next_cycle();
        bus.pt_data = P2; bus.pt_last = 1'b0;
        for (int c = 1; c <= SETTLE; c++) begin
            #2;
            chk("bp_wait_ct_valid", 128'(bus.ct_valid), 128'd0);
            next_cycle();
        end
        for (int c = 0; c < 10; c++) begin
            #2;
            chk("bp_ct_valid", 128'(bus.ct_valid), 128'd1);
            chk("bp_ct_data", bus.ct_data, FCT);
            chk("bp_ct_last", 128'(bus.ct_last), 128'd1);
            chk("bp_pt_ready", 128'(bus.pt_ready), 128'd0);
            next_cycle();
        end
        bus.ct_ready = 1'b1;
        bus.pt_valid = 1'b0;
        #2;
        chk("bp_release_valid", 128'(bus.ct_valid), 128'd1);
        next_cycle();
        #2;
        chk("bp_idle_busy", 128'(busy), 128'd0);
        chk("bp_idle_ct_valid", 128'(bus.ct_valid), 128'd0);
        next_cycle();

        // key_load while busy is dropped
        bus.pt_data = FPT; bus.pt_last = 1'b1; bus.pt_valid = 1'b1;
        #2;
        chk("kl_busy_accept", 128'(bus.pt_ready), 128'd1);
        next_cycle();
        bus.pt_valid = 1'b0;
        key_load = 1'b1; key_in = SK;
        #2;
        chk("kl_busy_pt_ready", 128'(bus.pt_ready), 128'd0);
        next_cycle();
        key_load = 1'b0;
        lat = 0;
        #2;
        while (!bus.ct_valid && lat < 50) begin
            next_cycle();
            #2;
            lat++;
        end
        chk("kl_busy_ct", bus.ct_data, FCT);
        next_cycle();
        send_block(FPT, 1'b1, ct, ct_l, lat);
        chk("kl_busy_old_key", ct, FCT);

        // key_load alongside pt_valid in IDLE: block waits a cycle, then uses the new key
        load(1'b0, 128'h0, 1'b1, SIV);
        key_load = 1'b1; key_in = SK;
        bus.pt_data = P1; bus.pt_last = 1'b0; bus.pt_valid = 1'b1;
        #2;
        chk("kl_idle_pt_ready", 128'(bus.pt_ready), 128'd0);
        next_cycle();
        key_load = 1'b0;
        send_block(P1, 1'b0, ct, ct_l, lat);
        chk("kl_idle_new_key", ct, C1);
        chk("kl_idle_latency", 128'(lat), 128'(SETTLE + 1));

        // reset in the middle of WAIT
        load(1'b1, FK, 1'b1, 128'h0);
        bus.pt_data = FPT; bus.pt_last = 1'b1; bus.pt_valid = 1'b1;
        next_cycle();
        bus.pt_valid = 1'b0;
        reset = 1'b1;
        #2;
        chk("rw_busy_before", 128'(busy), 128'd1);
        next_cycle();
        reset = 1'b0;
        #2;
        chk("rw_busy", 128'(busy), 128'd0);
        chk("rw_core_key", core_key, 128'h0);
        chk("rw_core_text", core_text, 128'h0);
        chk("rw_ct_data", bus.ct_data, 128'h0);
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("rw_no_ct_valid", 128'(bus.ct_valid), 128'd0);
            next_cycle();
        end
        load(1'b1, FK, 1'b1, 128'h0);
        send_block(FPT, 1'b1, ct, ct_l, lat);
        chk("rw_fips_ct", ct, FCT);

        // randomized traffic against the CBC reference model
        begin
            logic [127:0] m_key, m_iv, m_chain, m_ct, kin, ivn, pd;
            logic         m_last, kl, il, pv, pl, cr, exp_ready, exp_valid;
            int           phase;
            m_key = FK; m_iv = 128'h0; m_chain = 128'h0; m_ct = '0; m_last = 1'b0;
            phase = 0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                kl  = ($urandom_range(0, 9) == 0);
                il  = ($urandom_range(0, 9) == 0);
                kin = {$urandom(), $urandom(), $urandom(), $urandom()};
                ivn = {$urandom(), $urandom(), $urandom(), $urandom()};
                pd  = {$urandom(), $urandom(), $urandom(), $urandom()};
                pv  = ($urandom_range(0, 2) != 0);
                pl  = ($urandom_range(0, 2) == 0);
                cr  = ($urandom_range(0, 3) != 0);
                key_load = kl; key_in = kin; iv_load = il; iv_in = ivn;
                bus.pt_valid = pv; bus.pt_data = pd; bus.pt_last = pl; bus.ct_ready = cr;
                #2;
                exp_ready = (phase == 0) && !kl && !il;
                exp_valid = (phase >= SETTLE + 1);
                chk("rnd_busy", 128'(busy), 128'(phase != 0));
                chk("rnd_pt_ready", 128'(bus.pt_ready), 128'(exp_ready));
                chk("rnd_ct_valid", 128'(bus.ct_valid), 128'(exp_valid));
                chk("rnd_ct_last", 128'(bus.ct_last), 128'(exp_valid && m_last));
                if (exp_valid) chk("rnd_ct_data", bus.ct_data, m_ct);
                if (phase == 0) begin
                    if (kl) m_key = kin;
                    if (il) begin
                        m_iv = ivn;
                        m_chain = ivn;
                    end
                    if (pv && exp_ready) begin
                        m_ct    = aes_enc(m_key, pd ^ m_chain);
                        m_last  = pl;
                        m_chain = pl ? m_iv : m_ct;
                        phase   = 1;
                    end
                end else if (phase >= SETTLE + 1) begin
                    if (cr) phase = 0;
                end else begin
                    phase++;
                end
                next_cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_cbc_ctrl.md
Name: aes_cbc_ctrl

Overview:
Sequential CBC-mode controller that sits directly upstream of the combinational AES-128 encryption core and consumes its output. It accepts 128-bit plaintext blocks over a valid/ready handshake and XORs each block with the chaining value (IV or previous ciphertext). It holds the result and the key stable on the core inputs for a fixed multicycle settle window, captures the core's ciphertext, and presents it downstream over a valid/ready handshake.

Parameters:
SETTLE_CYCLES, 2, clock cycles the core inputs are held before capturing core_cipher; legal range 1..15.
CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
key_load  input  1  load key_in into key register (honoured only in IDLE)
key_in  input  128  AES-128 cipher key
iv_load  input  1  load iv_in into IV and chain registers (honoured only in IDLE)
iv_in  input  128  initialisation vector
pt_valid  input  1  plaintext block valid
pt_ready  output  1  controller can accept a plaintext block
pt_data  input  128  plaintext block
pt_last  input  1  block is the last of a message
ct_valid  output  1  ciphertext block valid
ct_ready  input  1  downstream accepts ciphertext
ct_data  output  128  ciphertext block
ct_last  output  1  ciphertext is the last of a message
core_text  output  128  to core ip_text (registered)
core_key  output  128  to core ip_key (registered)
core_cipher  input  128  from core op_cipher
busy  output  1  high in WAIT or OUT

Behaviour:
- Reset (sync, high): state=IDLE; key_reg, iv_reg, chain_reg, text_reg, ct_reg, cnt all 0; last_reg=0. Outputs: pt_ready=0 while reset is high; ct_valid=0, ct_data=0, ct_last=0, busy=0, core_text=0, core_key=0. Reset mid-operation aborts the block; nothing is emitted.
- core_text=text_reg; core_key=key_reg; ct_data=ct_reg; ct_last=last_reg in OUT, else 0.
- States: IDLE, WAIT, OUT.
- IDLE:
  - pt_ready = ~reset & ~key_load & ~iv_load.
  - key_load: key_reg<=key_in.
  - iv_load: iv_reg<=iv_in and chain_reg<=iv_in.
  - key_load and iv_load may occur in the same cycle; both take effect.
  - Any load blocks the plaintext handshake that cycle.
  - On pt_valid&pt_ready: text_reg<=pt_data^chain_reg; last_reg<=pt_last; cnt<=SETTLE_CYCLES; go to WAIT.
- WAIT: pt_ready=0. cnt decrements each cycle. On the edge where cnt==1: ct_reg<=core_cipher; chain_reg<=core_cipher; go to OUT.
- OUT: ct_valid=1. ct_data and ct_last are held stable until ct_ready. On ct_valid&ct_ready: go to IDLE, and if last_reg, chain_reg<=iv_reg (next message restarts from the IV).
- key_load and iv_load in WAIT/OUT are ignored; registers are unchanged.
- Latency: handshake in cycle 0 -> WAIT for cycles 1..SETTLE_CYCLES -> ct_valid first high in cycle SETTLE_CYCLES+1. Minimum block period is SETTLE_CYCLES+2 cycles when ct_ready is held high.
- Backpressure: ct_ready low holds OUT indefinitely; pt_ready stays 0 throughout.
- pt_valid low in IDLE: remain in IDLE; no register changes other than loads.
- The core path is a SETTLE_CYCLES multicycle path from text_reg/key_reg to ct_reg/chain_reg. This constraint must be applied at synthesis.

Test Plan:
- FIPS-197, real core attached, SETTLE_CYCLES=2: key 000102030405060708090a0b0c0d0e0f, IV 0, pt 00112233445566778899aabbccddeeff, pt_last=1 -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, ct_last=1, ct_valid first high exactly 3 cycles after the handshake.
- SP800-38A CBC chain: key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f; P1 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d; then P2 ae2d8a571e03ac9c9eb76fac45af8e51 (last) -> 5086cb9b507219ee95db113a917678b2.
- Message restart: after the previous scenario's last block, resend P1 with no iv_load -> 7649abac8119b246cee98e9b12e9197d again, because chain_reg reverted to the IV.
- Backpressure: hold ct_ready=0 for 10 cycles in OUT -> ct_valid, ct_data, ct_last stable; pt_ready=0; a new pt_valid is not accepted; release -> return to IDLE one cycle later.
- Loads: key_load while busy -> ignored (next block uses the old key). key_load with pt_valid in IDLE -> pt_ready=0, key updated, block accepted the following cycle with the new key.
- Reset mid-WAIT: assert reset for 1 cycle -> no ct_valid; all outputs 0; a subsequent FIPS-197 block after reloading the key gives the correct ciphertext.
